// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between NUM_REQ requesters.
// Rev 1.0 -- initial release.
`default_nettype none

module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  input  logic [3*NUM_REQ-1:0]    req_op,
  input  logic [NUM_REQ-1:0]      req_rev,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [2:0]              alu_op,
  output logic                    alu_rev,
  input  logic [31:0]             alu_result,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [31:0]             resp_result,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] tag;
  logic [ID_W-1:0] grant_idx;
  logic            grant_valid;
  logic [ID_W:0]   cand;

  // Scan last_grant+1, +2, ... with one spare bit so the wrap is a single subtract.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_valid && req_valid[cand[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign req_ready = (state == ST_IDLE && grant_valid) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= ID_W'(NUM_REQ - 1);
      tag         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_rev     <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            alu_a      <= req_a[32*grant_idx +: 32];
            alu_b      <= req_b[32*grant_idx +: 32];
            alu_op     <= req_op[3*grant_idx +: 3];
            alu_rev    <= req_rev[grant_idx];
            tag        <= grant_idx;
            last_grant <= grant_idx;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_result <= alu_result;
          resp_id     <= tag;
          resp_valid  <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          // No skid buffer: nothing new is accepted until this response leaves.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, directed corner sequences and randomized scoreboard for alu_arbiter.
`default_nettype none

module tb_alu_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [3*NUM_REQ-1:0]  req_op;
  logic [NUM_REQ-1:0]    req_rev;
  logic [31:0]           alu_a, alu_b, alu_result;
  logic [2:0]            alu_op;
  logic                  alu_rev;
  logic                  resp_valid, resp_ready, busy;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_rev(req_rev),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rev(alu_rev),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: rev swaps the operands before the operation.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic rev);
    logic [31:0] x, y;
    x = rev ? b : a;
    y = rev ? a : b;
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return x << y[4:0];
      3'd6: return x >> y[4:0];
      default: return {31'b0, (x < y)};
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op, alu_rev);

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic rev);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
    req_rev[i]        = rev;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_alu_a",      alu_a,           32'd0);
  endtask

  // Single op through an idle arbiter with only requester id valid.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic rev, input logic [31:0] exp);
    @(posedge clk); #1;
    set_req(id, a, b, op, rev);
    req_valid = NUM_REQ'(1) << id;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("op_ready", 32'(req_ready), 32'(NUM_REQ'(1) << id));
    @(posedge clk); #1;
    req_valid = '0;
    set_req(id, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    @(negedge clk);
    chk("op_exec_valid", 32'(resp_valid), 32'd0);
    chk("op_alu_a", alu_a, a);
    @(negedge clk);
    chk("op_resp_valid",  32'(resp_valid), 32'd1);
    chk("op_resp_id",     32'(resp_id),    32'(id));
    chk("op_resp_result", resp_result,     exp);
    @(negedge clk);
    chk("op_resp_done", 32'(resp_valid), 32'd0);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        rev;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    int          gcyc;
  } exp_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    exp_t q[$];
    logic [NUM_REQ-1:0] pend;
    int wait_cnt[NUM_REQ];
    int grants, resps, last_gc, exp_g, exp_r, g, m_last, cyc, accepted, waited;
    logic m_busy, head_seen;

    rst_n = 1'b1; req_valid = '0; resp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_rev = '0;

    tbl[0] = '{0, 32'd5,          32'd3,          3'd0, 1'b0, 32'd8};
    tbl[1] = '{1, 32'd5,          32'd3,          3'd1, 1'b0, 32'd2};
    tbl[2] = '{0, 32'd5,          32'd3,          3'd1, 1'b1, 32'hFFFF_FFFE};
    tbl[3] = '{1, 32'hF0F0_0000,  32'hFF00_FF00,  3'd2, 1'b0, 32'hF000_0000};
    tbl[4] = '{0, 32'h0000_1200,  32'h0000_0034,  3'd3, 1'b0, 32'h0000_1234};
    tbl[5] = '{1, 32'hFFFF_FFFF,  32'd1,          3'd0, 1'b0, 32'd0};
    tbl[6] = '{0, 32'd4,          32'd1,          3'd5, 1'b1, 32'h0000_0010};
    tbl[7] = '{1, 32'hDEAD_BEEF,  32'd0,          3'd4, 1'b0, 32'hDEAD_BEEF};

    reset_dut();
    for (int i = 0; i < 8; i++)
      do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].rev, tbl[i].exp);

    // Contention: both requesters held valid, grants must alternate from 0.
    reset_dut();
    @(posedge clk); #1;
    set_req(0, 32'd10, 32'd1, 3'd0, 1'b0);
    set_req(1, 32'd20, 32'd2, 3'd0, 1'b0);
    req_valid = '1; resp_ready = 1'b1;
    grants = 0; resps = 0; last_gc = -1; exp_g = 0; exp_r = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("cont_grant", 32'(req_ready), 32'(NUM_REQ'(1) << exp_g));
        if (last_gc >= 0) chk("cont_spacing", 32'(c - last_gc), 32'd3);
        last_gc = c; exp_g = (exp_g + 1) % NUM_REQ; grants++;
      end
      if (resp_valid) begin
        chk("cont_resp_id", 32'(resp_id), 32'(exp_r));
        chk("cont_resp_result", resp_result, (exp_r == 0) ? 32'd11 : 32'd22);
        exp_r = (exp_r + 1) % NUM_REQ; resps++;
      end
    end
    chk("cont_grants", 32'(grants), 32'd4);
    chk("cont_resps",  32'(resps),  32'd4);
    @(posedge clk); #1 req_valid = '0;

    // Backpressure with DEADBEEF pending.
    @(posedge clk); #1;
    set_req(0, 32'hDEAD_BEEF, 32'd0, 3'd4, 1'b0);
    req_valid = 2'b01; resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = '1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_resp_valid",  32'(resp_valid), 32'd1);
      chk("bp_resp_result", resp_result,     32'hDEAD_BEEF);
      chk("bp_resp_id",     32'(resp_id),    32'd0);
      chk("bp_req_ready",   32'(req_ready),  32'd0);
    end
    @(posedge clk); #1 resp_ready = 1'b1; req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_accepted", 32'(resp_valid), 32'd0);
    chk("bp_idle",     32'(busy),       32'd0);

    // Reset while in EXEC: operation dropped, next grant back to requester 0.
    @(posedge clk); #1;
    set_req(1, 32'd7, 32'd7, 3'd0, 1'b0);
    req_valid = 2'b10;
    @(negedge clk);
    chk("rmo_grant", 32'(req_ready), 32'd2);
    @(posedge clk); #1 req_valid = '0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rmo_no_resp", 32'(resp_valid), 32'd0);
      chk("rmo_busy",    32'(busy),       32'd0);
    end
    chk("rmo_alu_a", alu_a, 32'd0);
    @(posedge clk); #1 req_valid = '1;
    @(negedge clk);
    chk("rmo_next_grant", 32'(req_ready), 32'd1);

    // Randomized traffic against the scoreboard.
    reset_dut();
    pend = '0; m_busy = 1'b0; m_last = NUM_REQ - 1; cyc = 0; accepted = 0; head_seen = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    while (accepted < 1000 && cyc < 30000) begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i] = 1'b1;
          set_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
      end
      req_valid  = pend;
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!m_busy && pend != '0) begin
        g = rr_pick(pend, m_last);
        chk("rand_ready", 32'(req_ready), 32'(NUM_REQ'(1) << g));
        q.push_back('{g, alu_model(req_a[32*g +: 32], req_b[32*g +: 32],
                                   req_op[3*g +: 3], req_rev[g]), cyc});
        for (int j = 0; j < NUM_REQ; j++) begin
          if (j != g && pend[j]) begin
            wait_cnt[j]++;
            waited = wait_cnt[j];
            if (waited >= NUM_REQ) chk("rand_starve", 32'(waited), 32'(NUM_REQ - 1));
          end
        end
        wait_cnt[g] = 0; pend[g] = 1'b0; m_last = g; m_busy = 1'b1; accepted++;
      end else begin
        chk("rand_ready_idle", 32'(req_ready), 32'd0);
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("rand_spurious_resp", 32'(resp_valid), 32'd0);
        end else begin
          if (!head_seen) chk("rand_latency", 32'(cyc - q[0].gcyc), 32'd2);
          head_seen = 1'b1;
          chk("rand_resp_id",     32'(resp_id), 32'(q[0].id));
          chk("rand_resp_result", resp_result,  q[0].res);
          if (resp_ready) begin
            void'(q.pop_front());
            m_busy = 1'b0; head_seen = 1'b0;
          end
        end
      end else if (q.size() > 0 && (cyc - q[0].gcyc) >= 2) begin
        chk("rand_resp_late", 32'(resp_valid), 32'd1);
      end
    end
    chk("rand_accepted", 32'(accepted), 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
